// File: rtl/sm_hex_display_capture_pkg.sv
// Shared constants for the scanned 7-segment capture path: bus layout and the
// active-high gfedcba encodings of the sixteen hex glyphs.
package sm_hex_display_capture_pkg;

    localparam int unsigned BUS_W    = 12;
    localparam int unsigned SEG_LSB  = 0;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned SEL_LSB  = 8;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned SAMPLE_W = SEL_W + SEG_W;

    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

endpackage

// File: rtl/sm_seg7_decode.sv
// Combinational inverse of the hex 7-segment encoder: active-high gfedcba
// pattern to nibble, with hit low for any pattern that is not a hex glyph.
module sm_seg7_decode
    import sm_hex_display_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            default:   hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/sm_hex_display_capture.sv
// Captures a multiplexed 7-segment scan bus back into a hex value: synchroniser,
// dwell filter, per-digit shadow/mask frame assembly and link timeout.
module sm_hex_display_capture
    import sm_hex_display_capture_pkg::*;
#(
    parameter int unsigned DIGITS         = 3,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BUS_W-1:0]      seg_bus_in,
    output logic [4*DIGITS-1:0]   value,
    output logic                  frame_valid,
    output logic                  decode_err,
    output logic                  link_ok
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned VW = 4 * DIGITS;
    localparam logic [CW-1:0]    STABLE_MAX  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0]    TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [SEL_W-1:0] DIG_MASK    = SEL_W'((1 << DIGITS) - 1);

    logic [BUS_W-1:0]    sync1_q, sync2_q, bus;
    logic [SEL_W-1:0]    sel;
    logic [SEG_W-1:0]    seg;
    logic [SAMPLE_W-1:0] sample, prev_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                armed_q, armed_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                seen_q, seen_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [VW-1:0]       shadow_q, shadow_d, value_q, value_d;
    logic                fv_q, fv_d, err_q, err_d;
    logic                sel_ok, attempt, valid_cap, dec_hit;
    logic [3:0]          dec_nibble;
    logic                unused_dp;

    assign bus       = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign sel       = bus[SEL_LSB +: SEL_W];
    assign seg       = bus[SEG_LSB +: SEG_W];
    assign unused_dp = bus[7];
    assign sample    = {sel, seg};
    assign sel_ok    = $onehot(sel) && ((sel & ~DIG_MASK) == '0);

    sm_seg7_decode u_decode (
        .seg    (seg),
        .hit    (dec_hit),
        .nibble (dec_nibble)
    );

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (sample != prev_q) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Capture fires in the cycle the dwell count reaches its limit, once per dwell.
        attempt   = armed_q && (cnt_d == STABLE_MAX) && sel_ok;
        valid_cap = attempt && dec_hit;
        if (attempt) armed_d = 1'b0;
        err_d = attempt && !dec_hit;

        tcnt_d = tcnt_q;
        if (valid_cap)                 tcnt_d = '0;
        else if (tcnt_q != TIMEOUT_MAX) tcnt_d = tcnt_q + 1'b1;
        seen_d = seen_q | valid_cap;

        mask_d   = mask_q;
        shadow_d = shadow_q;
        value_d  = value_q;
        fv_d     = 1'b0;
        if (&mask_q) begin
            value_d = shadow_q;
            fv_d    = 1'b1;
            mask_d  = '0;
        end else if (tcnt_d == TIMEOUT_MAX) begin
            mask_d = '0;
        end
        // Applied after completion so a same-cycle capture starts the next frame.
        if (valid_cap) begin
            mask_d = mask_d | sel[DIGITS-1:0];
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (sel[i]) shadow_d[4*i +: 4] = dec_nibble;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b1;
            tcnt_q   <= '0;
            seen_q   <= 1'b0;
            mask_q   <= '0;
            shadow_q <= '0;
            value_q  <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= seg_bus_in;
            sync2_q  <= sync1_q;
            prev_q   <= sample;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            tcnt_q   <= tcnt_d;
            seen_q   <= seen_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            value_q  <= value_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = fv_q;
    assign decode_err  = err_q;
    assign link_ok     = seen_q && (tcnt_q != TIMEOUT_MAX);

endmodule
